// File: rtl/fetch_loader_pkg.sv
// Shared constants, entry type and hit-prefix helper for the fetch loader.
package fetch_loader_pkg;

    localparam int INSTR_W     = 32;
    localparam int INSTR_BYTES = 4;
    localparam int PKG_XLEN    = 32;
    localparam int MAX_WIDTH   = 4;

    typedef struct packed {
        logic [PKG_XLEN-1:0] address;
        logic [INSTR_W-1:0]  instr;
    } fetch_entry_t;

    // Counts hits from lane 0 up to the first miss; narrower callers zero-pad.
    function automatic logic [2:0] leading_ones(input logic [MAX_WIDTH-1:0] hit);
        logic [2:0] k;
        logic       run;
        k   = 3'd0;
        run = 1'b1;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (run && hit[i]) begin
                k = k + 3'd1;
            end else begin
                run = 1'b0;
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/fetch_loader_if.sv
// Cache request/response, redirect and decode-side signals of the fetch loader.
interface fetch_loader_if #(
    parameter int XLEN  = 32,
    parameter int WIDTH = 2
);
    import fetch_loader_pkg::*;

    logic                             redirect_valid;
    logic [XLEN-1:0]                  redirect_pc;
    logic [WIDTH-1:0]                 cache_read;
    logic [WIDTH-1:0][XLEN-1:0]       cache_address;
    logic [WIDTH-1:0]                 cache_hit;
    logic [WIDTH-1:0][INSTR_W-1:0]    cache_data;
    logic [WIDTH-1:0]                 out_valid;
    logic [WIDTH-1:0][XLEN-1:0]       out_address;
    logic [WIDTH-1:0][INSTR_W-1:0]    out_instr;
    logic                             stop;

    modport master (
        input  redirect_valid, redirect_pc, cache_hit, cache_data, stop,
        output cache_read, cache_address, out_valid, out_address, out_instr
    );

    modport slave (
        output redirect_valid, redirect_pc, cache_hit, cache_data, stop,
        input  cache_read, cache_address, out_valid, out_address, out_instr
    );

endinterface

// File: rtl/fetch_loader_queue.sv
// Circular instruction queue with WIDTH push lanes and a WIDTH-wide head window.
module fetch_queue
    import fetch_loader_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int WIDTH = 2,
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(WIDTH + 1),
    localparam int AW    = $clog2(DEPTH),
    localparam int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [CW-1:0]                 push_count,
    input  logic [WIDTH-1:0][XLEN-1:0]    push_address,
    input  logic [WIDTH-1:0][INSTR_W-1:0] push_instr,
    input  logic [CW-1:0]                 pop_count,
    output logic [CNTW-1:0]               count,
    output logic [WIDTH-1:0]              head_valid,
    output logic [WIDTH-1:0][XLEN-1:0]    head_address,
    output logic [WIDTH-1:0][INSTR_W-1:0] head_instr
);

    logic [XLEN-1:0]    mem_address [DEPTH];
    logic [INSTR_W-1:0] mem_instr   [DEPTH];
    logic [AW-1:0]      head;
    logic [AW-1:0]      tail;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(pop_count);
            tail  <= tail + AW'(push_count);
            count <= count + CNTW'(push_count) - CNTW'(pop_count);
        end
    end

    always_ff @(posedge clock) begin
        if (reset && !flush) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (CW'(i) < push_count) begin
                    mem_address[tail + AW'(i)] <= push_address[i];
                    mem_instr[tail + AW'(i)]   <= push_instr[i];
                end
            end
        end
    end

    // Empty lanes read as zero so decode never sees stale storage.
    always_comb begin
        head_valid   = '0;
        head_address = '0;
        head_instr   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            head_valid[i] = count > CNTW'(i);
            if (head_valid[i]) begin
                head_address[i] = mem_address[head + AW'(i)];
                head_instr[i]   = mem_instr[head + AW'(i)];
            end
        end
    end

endmodule

// File: rtl/fetch_loader.sv
// Fetch PC, WIDTH-lane cache request, hit-prefix enqueue and redirect handling.
// Optional FETCH_LOADER_PERF_EN adds saturating miss/full/redirect counters.
module fetch_loader
    import fetch_loader_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              WIDTH    = 2,
    parameter int              DEPTH    = 8,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic          clock,
    input  logic          reset,
    fetch_loader_if.master bus
`ifdef FETCH_LOADER_PERF_EN
    ,
    output logic [31:0]   perf_miss_cycles,
    output logic [31:0]   perf_full_cycles,
    output logic [31:0]   perf_redirects
`endif
);

    localparam int CW   = $clog2(WIDTH + 1);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [XLEN-1:0]                 pc;
    logic                            fetch_en;
    logic [2:0]                      k;
    logic [CW-1:0]                   push_count;
    logic [CW-1:0]                   pop_count;
    logic [CNTW-1:0]                 count;
    logic [WIDTH-1:0]                q_valid;
    logic [WIDTH-1:0][XLEN-1:0]      q_address;
    logic [WIDTH-1:0][INSTR_W-1:0]   q_instr;

    // Free space uses the registered count so stop has no path to the cache.
    always_comb begin
        fetch_en       = reset && !bus.redirect_valid
                         && ((CNTW'(DEPTH) - count) >= CNTW'(WIDTH));
        bus.cache_read = {WIDTH{fetch_en}};
        k              = fetch_en ? leading_ones(MAX_WIDTH'(bus.cache_hit)) : 3'd0;
        push_count     = CW'(k);
        if (bus.stop) begin
            pop_count = '0;
        end else if (count < CNTW'(WIDTH)) begin
            pop_count = CW'(count);
        end else begin
            pop_count = CW'(WIDTH);
        end
        bus.cache_address = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bus.cache_address[i] = pc + XLEN'(INSTR_BYTES * i);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (bus.redirect_valid) begin
            pc <= bus.redirect_pc & ~XLEN'(3);
        end else begin
            pc <= pc + (XLEN'(k) << 2);
        end
    end

    fetch_queue #(
        .XLEN  (XLEN),
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) queue (
        .clock        (clock),
        .reset        (reset),
        .flush        (bus.redirect_valid),
        .push_count   (push_count),
        .push_address (bus.cache_address),
        .push_instr   (bus.cache_data),
        .pop_count    (pop_count),
        .count        (count),
        .head_valid   (q_valid),
        .head_address (q_address),
        .head_instr   (q_instr)
    );

    assign bus.out_valid   = q_valid;
    assign bus.out_address = q_address;
    assign bus.out_instr   = q_instr;

`ifdef FETCH_LOADER_PERF_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            perf_miss_cycles <= '0;
            perf_full_cycles <= '0;
            perf_redirects   <= '0;
        end else begin
            if (fetch_en && k == 3'd0 && perf_miss_cycles != '1) begin
                perf_miss_cycles <= perf_miss_cycles + 32'd1;
            end
            if (!fetch_en && !bus.redirect_valid && perf_full_cycles != '1) begin
                perf_full_cycles <= perf_full_cycles + 32'd1;
            end
            if (bus.redirect_valid && perf_redirects != '1) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
        end
    end
`endif

endmodule
